// File: rtl/uc_escalonador_jogo.sv
// Game-tick scheduler: paces frames with a tick counter, sequences the shot, asteroid
// and collision controllers over start/done handshakes, and arbitrates fire requests in.
module uc_escalonador_jogo #(
    parameter int PERIODO_TICK = 50000000,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       atirar,
    input  logic       tiro_registrado,
    input  logic       movimentacao_concluida_tiro,
    input  logic       movimentacao_concluida_asteroide,
    input  logic       colisao_concluida,
    output logic       registra_tiro,
    output logic       movimenta_tiro,
    output logic       movimenta_asteroide,
    output logic       verifica_colisao,
    output logic       fim_ciclo,
    output logic       overrun,
    output logic       erro_timeout,
    output logic [4:0] db_estado
);

    localparam logic [4:0] INICIO         = 5'h00;
    localparam logic [4:0] ESPERA         = 5'h01;
    localparam logic [4:0] REGISTRA_TIRO  = 5'h02;
    localparam logic [4:0] MOVE_TIROS     = 5'h03;
    localparam logic [4:0] ESPERA_TIROS   = 5'h04;
    localparam logic [4:0] MOVE_AST       = 5'h05;
    localparam logic [4:0] ESPERA_AST     = 5'h06;
    localparam logic [4:0] COLISAO        = 5'h07;
    localparam logic [4:0] ESPERA_COLISAO = 5'h08;
    localparam logic [4:0] FIM_CICLO      = 5'h09;
    localparam logic [4:0] ERRO           = 5'h1F;

    localparam int CNT_W = (PERIODO_TICK > 1) ? $clog2(PERIODO_TICK) : 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIODO_TICK - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT - 1);

    logic [4:0]       estado_reg, estado_next;
    logic [CNT_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             tick_pendente_reg, tick_pendente_next;
    logic             pedido_tiro_reg, pedido_tiro_next;
    logic             atirar_q_reg;
    logic             overrun_reg, overrun_next;

    logic tick_wrap;
    logic consome_tick;
    logic borda_tiro;
    logic sai_registro;
    logic em_espera;
    logic wd_estouro;

    assign tick_wrap    = iniciar && (tick_cnt_reg == CNT_MAX);
    assign consome_tick = (estado_reg == ESPERA) && iniciar && !pedido_tiro_reg && tick_pendente_reg;
    assign borda_tiro   = atirar && !atirar_q_reg;
    assign sai_registro = (estado_reg == REGISTRA_TIRO) && (estado_next != REGISTRA_TIRO);
    assign wd_estouro   = (wd_reg == WD_MAX);

    always_comb begin
        em_espera = 1'b0;
        case (estado_reg)
            REGISTRA_TIRO, ESPERA_TIROS, ESPERA_AST, ESPERA_COLISAO: em_espera = 1'b1;
            default:                                                 em_espera = 1'b0;
        endcase
    end

    // The tick counter free-runs across a frame; a wrap still pending at the next wrap is an overrun.
    always_comb begin
        tick_cnt_next      = tick_cnt_reg;
        tick_pendente_next = tick_pendente_reg;
        if (!iniciar) begin
            tick_cnt_next      = '0;
            tick_pendente_next = 1'b0;
        end else if (tick_wrap) begin
            tick_cnt_next      = '0;
            tick_pendente_next = 1'b1;
        end else begin
            tick_cnt_next = tick_cnt_reg + CNT_W'(1);
            if (consome_tick) begin
                tick_pendente_next = 1'b0;
            end
        end
        overrun_next = overrun_reg || (tick_wrap && tick_pendente_reg);
    end

    // A new fire edge overrides the clear that happens on leaving REGISTRA_TIRO.
    always_comb begin
        pedido_tiro_next = pedido_tiro_reg;
        if (borda_tiro) begin
            pedido_tiro_next = 1'b1;
        end else if (sai_registro) begin
            pedido_tiro_next = 1'b0;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            INICIO: estado_next = ESPERA;
            ESPERA: begin
                if (iniciar && pedido_tiro_reg) begin
                    estado_next = REGISTRA_TIRO;
                end else if (iniciar && tick_pendente_reg) begin
                    estado_next = MOVE_TIROS;
                end
            end
            REGISTRA_TIRO: begin
                if (tiro_registrado) begin
                    estado_next = ESPERA;
                end else if (wd_estouro) begin
                    estado_next = ERRO;
                end
            end
            MOVE_TIROS: estado_next = ESPERA_TIROS;
            ESPERA_TIROS: begin
                if (movimentacao_concluida_tiro) begin
                    estado_next = MOVE_AST;
                end else if (wd_estouro) begin
                    estado_next = ERRO;
                end
            end
            MOVE_AST: estado_next = ESPERA_AST;
            ESPERA_AST: begin
                if (movimentacao_concluida_asteroide) begin
                    estado_next = COLISAO;
                end else if (wd_estouro) begin
                    estado_next = ERRO;
                end
            end
            COLISAO: estado_next = ESPERA_COLISAO;
            ESPERA_COLISAO: begin
                if (colisao_concluida) begin
                    estado_next = FIM_CICLO;
                end else if (wd_estouro) begin
                    estado_next = ERRO;
                end
            end
            FIM_CICLO: estado_next = ESPERA;
            ERRO:      estado_next = ERRO;
            default:   estado_next = INICIO;
        endcase
    end

    // Watchdog restarts at zero on every entry to a wait state and counts while it stays there.
    always_comb begin
        wd_next = '0;
        if (em_espera && (estado_next == estado_reg)) begin
            wd_next = wd_reg + WD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg        <= INICIO;
            tick_cnt_reg      <= '0;
            wd_reg            <= '0;
            tick_pendente_reg <= 1'b0;
            pedido_tiro_reg   <= 1'b0;
            atirar_q_reg      <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            estado_reg        <= estado_next;
            tick_cnt_reg      <= tick_cnt_next;
            wd_reg            <= wd_next;
            tick_pendente_reg <= tick_pendente_next;
            pedido_tiro_reg   <= pedido_tiro_next;
            atirar_q_reg      <= atirar;
            overrun_reg       <= overrun_next;
        end
    end

    assign registra_tiro       = (estado_reg == REGISTRA_TIRO);
    assign movimenta_tiro      = (estado_reg == MOVE_TIROS);
    assign movimenta_asteroide = (estado_reg == MOVE_AST);
    assign verifica_colisao    = (estado_reg == COLISAO);
    assign fim_ciclo           = (estado_reg == FIM_CICLO);
    assign erro_timeout        = (estado_reg == ERRO);
    assign overrun             = overrun_reg;
    assign db_estado           = estado_reg;

endmodule
